// File: rtl/guess_if.sv
// Command and status bundle between a host and the guess_engine game core.
interface guess_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  logic                          start;
  logic                          digit_valid;
  logic [DIGIT_W-1:0]            digit_in;
  logic                          check;
  logic [NUM_DIGITS*DIGIT_W-1:0] guess_bus;
  logic [3:0]                    entry_count;
  logic [NUM_DIGITS*DIGIT_W-1:0] secret_bus;
  logic [3:0]                    a_count;
  logic [3:0]                    b_count;
  logic                          result_valid;
  logic [7:0]                    tries;
  logic                          in_error;
  logic                          win;
  logic                          lose;
  logic                          busy;

  modport master (
    output start, digit_valid, digit_in, check,
    input  guess_bus, entry_count, secret_bus, a_count, b_count,
           result_valid, tries, in_error, win, lose, busy
  );

  modport slave (
    input  start, digit_valid, digit_in, check,
    output guess_bus, entry_count, secret_bus, a_count, b_count,
           result_valid, tries, in_error, win, lose, busy
  );
endinterface

// File: rtl/guess_engine.sv
// Bulls-and-cows style guessing game: LFSR-generated secret of distinct digits,
// digit entry with error flagging, and a one-digit-per-cycle scorer.
module guess_engine #(
  parameter int NUM_DIGITS = 4,
  parameter int BASE       = 10,
  parameter int DIGIT_W    = 4,
  parameter int MAX_TRIES  = 8
) (
  input  logic   clock,
  input  logic   rst,
  guess_if.slave gi
);
  localparam int BUS_W = NUM_DIGITS * DIGIT_W;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GEN    = 3'd1;
  localparam logic [2:0] ENTRY  = 3'd2;
  localparam logic [2:0] CMP    = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;
  localparam logic [2:0] WIN    = 3'd5;
  localparam logic [2:0] LOSE   = 3'd6;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [3:0]  FULL      = 4'(NUM_DIGITS);
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_DIGITS - 1);
  localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);

  logic [2:0]         state;
  logic [15:0]        lfsr;
  logic [BUS_W-1:0]   secret;
  logic [BUS_W-1:0]   guess;
  logic [3:0]         entry_cnt;
  logic [3:0]         gen_cnt;
  logic [3:0]         cmp_idx;
  logic [3:0]         a_acc;
  logic [3:0]         b_acc;
  logic               dup_acc;
  logic [3:0]         a_cnt;
  logic [3:0]         b_cnt;
  logic [7:0]         tries_cnt;
  logic               res_vld;
  logic               err;
  logic               won;
  logic               lost;

  logic [DIGIT_W-1:0] cand;
  logic               cand_ok;
  logic [DIGIT_W-1:0] g_dig;
  logic               hit_a;
  logic               hit_b;
  logic               hit_dup;

  function automatic logic [DIGIT_W-1:0] digit_at(input logic [BUS_W-1:0] bus,
                                                  input logic [3:0]       idx);
    return bus[int'(idx)*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic logic is_legal(input logic [DIGIT_W-1:0] d);
    return int'(d) < BASE;
  endfunction

  function automatic logic [BUS_W-1:0] shift_in(input logic [BUS_W-1:0]   bus,
                                                input logic [DIGIT_W-1:0] d);
    return {bus[BUS_W-DIGIT_W-1:0], d};
  endfunction

  // Accepted secret digits always sit in the low gen_cnt slots, so only those
  // take part in the distinctness test.
  always_comb begin
    cand    = lfsr[DIGIT_W-1:0];
    cand_ok = is_legal(cand);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i < int'(gen_cnt) && digit_at(secret, 4'(i)) == cand)
        cand_ok = 1'b0;
    end
  end

  always_comb begin
    g_dig   = digit_at(guess, cmp_idx);
    hit_a   = (g_dig == digit_at(secret, cmp_idx));
    hit_b   = 1'b0;
    hit_dup = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (4'(j) != cmp_idx && digit_at(secret, 4'(j)) == g_dig)
        hit_b = 1'b1;
      if (4'(j) < cmp_idx && digit_at(guess, 4'(j)) == g_dig)
        hit_dup = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)
      lfsr <= SEED;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      secret    <= '0;
      guess     <= '0;
      entry_cnt <= '0;
      gen_cnt   <= '0;
      cmp_idx   <= '0;
      a_acc     <= '0;
      b_acc     <= '0;
      dup_acc   <= 1'b0;
      a_cnt     <= '0;
      b_cnt     <= '0;
      tries_cnt <= '0;
      res_vld   <= 1'b0;
      err       <= 1'b0;
      won       <= 1'b0;
      lost      <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      if (gi.start) begin
        state     <= GEN;
        secret    <= '0;
        gen_cnt   <= '0;
        guess     <= '0;
        entry_cnt <= '0;
        tries_cnt <= '0;
        a_cnt     <= '0;
        b_cnt     <= '0;
        err       <= 1'b0;
        won       <= 1'b0;
        lost      <= 1'b0;
      end else begin
        case (state)
          GEN: begin
            if (cand_ok) begin
              secret  <= shift_in(secret, cand);
              gen_cnt <= gen_cnt + 4'd1;
              if (gen_cnt == LAST_IDX)
                state <= ENTRY;
            end
          end
          ENTRY: begin
            if (gi.check) begin
              if (entry_cnt == FULL) begin
                state   <= CMP;
                cmp_idx <= '0;
                a_acc   <= '0;
                b_acc   <= '0;
                dup_acc <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end else if (gi.digit_valid) begin
              if (is_legal(gi.digit_in)) begin
                guess <= shift_in(guess, gi.digit_in);
                if (entry_cnt != FULL)
                  entry_cnt <= entry_cnt + 4'd1;
                err <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          CMP: begin
            a_acc   <= a_acc + {3'b000, hit_a};
            b_acc   <= b_acc + {3'b000, hit_b};
            dup_acc <= dup_acc | hit_dup;
            cmp_idx <= cmp_idx + 4'd1;
            // A repeated guess digit is rejected without scoring; the guess
            // is discarded so the player re-enters it from scratch.
            if (cmp_idx == LAST_IDX) begin
              if (dup_acc | hit_dup) begin
                state     <= ENTRY;
                err       <= 1'b1;
                guess     <= '0;
                entry_cnt <= '0;
              end else begin
                state <= RESULT;
              end
            end
          end
          RESULT: begin
            res_vld   <= 1'b1;
            a_cnt     <= a_acc;
            b_cnt     <= b_acc;
            tries_cnt <= tries_cnt + 8'd1;
            if (a_acc == FULL) begin
              state <= WIN;
              won   <= 1'b1;
            end else if (tries_cnt + 8'd1 == TRY_LIMIT) begin
              state <= LOSE;
              lost  <= 1'b1;
            end else begin
              state     <= ENTRY;
              guess     <= '0;
              entry_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign gi.guess_bus    = guess;
  assign gi.entry_count  = entry_cnt;
  assign gi.secret_bus   = secret;
  assign gi.a_count      = a_cnt;
  assign gi.b_count      = b_cnt;
  assign gi.result_valid = res_vld;
  assign gi.tries        = tries_cnt;
  assign gi.in_error     = err;
  assign gi.win          = won;
  assign gi.lose         = lost;
  assign gi.busy         = (state == GEN) || (state == CMP) || (state == RESULT);
endmodule

// File: tb/tb_guess_engine.sv
// Self-checking bench for guess_engine: table of scored guesses plus hand-written
// sequences for entry errors, duplicates, losing, and reset during scoring.
`timescale 1ns/1ps
module tb_guess_engine;
  localparam int ND   = 4;
  localparam int BASE = 10;
  localparam int DW   = 4;
  localparam int MT   = 8;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_tries = 0;
  int   absent [4];

  guess_if #(.NUM_DIGITS(ND), .DIGIT_W(DW)) gi ();

  guess_engine #(.NUM_DIGITS(ND), .BASE(BASE), .DIGIT_W(DW), .MAX_TRIES(MT)) dut (
    .clock (clock),
    .rst   (rst),
    .gi    (gi)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tries;
    int win;
    int lose;
    int ecnt;
  } exp_t;

  // codes: one hex nibble per guess slot, slot ND-1 first (= first entered).
  // 0..3 pick that secret slot's digit, 4..7 pick a digit absent from the secret.
  typedef struct {
    logic [15:0] codes;
    int          a;
    int          b;
  } vec_t;

  exp_t sb [$];
  exp_t mon_e;
  vec_t tbl [7];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enter_digit(input int d);
    gi.digit_valid = 1'b1;
    gi.digit_in    = DW'(d);
    tick();
    gi.digit_valid = 1'b0;
  endtask

  function automatic int code_digit(input int code);
    if (code < ND)
      return int'(gi.secret_bus[code*DW +: DW]);
    return absent[code-ND];
  endfunction

  task automatic enter_codes(input logic [15:0] codes);
    logic [3:0] c;
    for (int k = 0; k < ND; k++) begin
      c = codes[15-4*k -: 4];
      enter_digit(code_digit(int'(c)));
    end
  endtask

  task automatic submit(input bit expect_res, input int a, input int b);
    exp_t e;
    if (expect_res) begin
      exp_tries++;
      e.cyc   = cyc + ND + 2;
      e.a     = a;
      e.b     = b;
      e.tries = exp_tries;
      e.win   = (a == ND) ? 1 : 0;
      e.lose  = (a != ND && exp_tries == MT) ? 1 : 0;
      e.ecnt  = (e.win == 1 || e.lose == 1) ? ND : 0;
      sb.push_back(e);
    end
    gi.check = 1'b1;
    tick();
    gi.check = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL result_timeout: %0d results still pending at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic wait_gen();
    bit ok;
    int n;
    for (int k = 0; k < 400 && gi.busy; k++) tick();
    cmp("gen_done_busy", gi.busy, 0);
    ok = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (code_digit(i) >= BASE) ok = 1'b0;
      for (int j = 0; j < i; j++)
        if (code_digit(i) == code_digit(j)) ok = 1'b0;
    end
    cmp("secret_legal_distinct", ok, 1);
    n = 0;
    for (int v = 0; v < BASE; v++) begin
      bit used;
      used = 1'b0;
      for (int i = 0; i < ND; i++)
        if (code_digit(i) == v) used = 1'b1;
      if (!used && n < 4) begin
        absent[n] = v;
        n++;
      end
    end
    exp_tries = 0;
  endtask

  task automatic new_game();
    gi.start = 1'b1;
    tick();
    gi.start = 1'b0;
    wait_gen();
  endtask

  always @(negedge clock) begin
    if (gi.result_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        cmp("result_latency", cyc, mon_e.cyc);
        cmp("a_count", gi.a_count, mon_e.a);
        cmp("b_count", gi.b_count, mon_e.b);
        cmp("tries", gi.tries, mon_e.tries);
        cmp("win", gi.win, mon_e.win);
        cmp("lose", gi.lose, mon_e.lose);
        cmp("entry_count_after_result", gi.entry_count, mon_e.ecnt);
      end
    end
  end

  initial begin
    logic [15:0] saved;

    gi.start       = 1'b0;
    gi.digit_valid = 1'b0;
    gi.digit_in    = '0;
    gi.check       = 1'b0;

    tbl[0] = '{16'h0321, 0, 4};
    tbl[1] = '{16'h3201, 2, 2};
    tbl[2] = '{16'h3245, 2, 0};
    tbl[3] = '{16'h4352, 0, 2};
    tbl[4] = '{16'h4567, 0, 0};
    tbl[5] = '{16'h3452, 1, 1};
    tbl[6] = '{16'h3210, 4, 0};

    repeat (3) tick();
    cmp("rst_buses", {gi.guess_bus, gi.secret_bus, gi.tries}, 0);
    cmp("rst_counts", {gi.entry_count, gi.a_count, gi.b_count}, 0);
    cmp("rst_flags", {gi.result_valid, gi.in_error, gi.win, gi.lose, gi.busy}, 0);
    #2 rst = 1'b1;
    tick();

    gi.check = 1'b1; gi.digit_valid = 1'b1; gi.digit_in = 4'd3;
    tick();
    gi.check = 1'b0; gi.digit_valid = 1'b0;
    repeat (ND + 3) tick();
    cmp("idle_ignores_inputs", {gi.busy, gi.entry_count, gi.tries, gi.guess_bus}, 0);

    new_game();
    for (int i = 0; i < 7; i++) begin
      enter_codes(tbl[i].codes);
      submit(1'b1, tbl[i].a, tbl[i].b);
      wait_drain();
    end
    submit(1'b0, 0, 0);
    repeat (ND + 4) tick();
    cmp("win_holds_tries", gi.tries, 7);
    cmp("win_holds_flag", gi.win, 1);

    new_game();
    cmp("start_clears_win", gi.win, 0);
    for (int i = 0; i < MT; i++) begin
      enter_codes(16'h4567);
      submit(1'b1, 0, 0);
      wait_drain();
    end
    submit(1'b0, 0, 0);
    repeat (ND + 4) tick();
    cmp("lose_holds_tries", gi.tries, MT);
    cmp("lose_holds_flag", gi.lose, 1);
    gi.start = 1'b1;
    tick();
    gi.start = 1'b0;
    cmp("start_clears_lose", {gi.lose, gi.tries, gi.a_count, gi.b_count}, 0);
    cmp("gen_busy", gi.busy, 1);
    wait_gen();

    enter_digit(2);
    cmp("entry_count_one", gi.entry_count, 1);
    saved = gi.guess_bus;
    enter_digit(12);
    cmp("illegal_guess_bus", gi.guess_bus, saved);
    cmp("illegal_entry_count", gi.entry_count, 1);
    cmp("illegal_in_error", gi.in_error, 1);
    enter_digit(3);
    cmp("legal_clears_error", {gi.in_error, gi.entry_count}, 5'h02);
    enter_digit(1); enter_digit(1); enter_digit(2); enter_digit(3);
    cmp("entry_saturates", gi.entry_count, ND);
    cmp("guess_packing", gi.guess_bus, 16'h1123);
    submit(1'b0, 0, 0);
    repeat (ND + 3) tick();
    cmp("dup_in_error", gi.in_error, 1);
    cmp("dup_tries", gi.tries, 0);
    cmp("dup_back_in_entry", gi.busy, 0);

    enter_digit(code_digit(0));
    cmp("dup_then_digit_clears", gi.in_error, 0);
    enter_digit(code_digit(1));
    enter_digit(code_digit(2));
    submit(1'b0, 0, 0);
    cmp("short_check_error", gi.in_error, 1);
    cmp("short_check_stays_entry", gi.busy, 0);

    gi.check = 1'b1; gi.digit_valid = 1'b1; gi.digit_in = 4'd7;
    tick();
    gi.check = 1'b0; gi.digit_valid = 1'b0;
    cmp("check_beats_digit", gi.entry_count, 3);

    enter_codes(16'h0321);
    submit(1'b1, 0, 4);
    wait_drain();

    enter_codes(16'h4567);
    gi.check = 1'b1;
    tick();
    gi.check = 1'b0;
    tick();
    cmp("cmp_busy_before_rst", gi.busy, 1);
    #2 rst = 1'b0;
    #1;
    cmp("midcmp_rst_buses", {gi.guess_bus, gi.secret_bus, gi.tries}, 0);
    cmp("midcmp_rst_counts", {gi.entry_count, gi.a_count, gi.b_count}, 0);
    cmp("midcmp_rst_flags", {gi.result_valid, gi.in_error, gi.win, gi.lose, gi.busy}, 0);
    #2 rst = 1'b1;
    tick();
    gi.check = 1'b1;
    tick();
    gi.check = 1'b0;
    repeat (ND + 4) tick();
    cmp("post_rst_check_ignored", {gi.busy, gi.tries, gi.entry_count, gi.a_count}, 0);

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete by %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
